// File: rtl/tcb_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : tcb_if
//  Description : TCB bus interface. The manager drives the request fields
//                (vld wen adr ben wdt); the subordinate drives rdy and the
//                delayed response fields (rdt err).
//  Revision    : 1.0  initial release
// ============================================================================
interface tcb_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic              vld;
    logic              wen;
    logic [AW-1:0]     adr;
    logic [DW/8-1:0]   ben;
    logic [DW-1:0]     wdt;
    logic              rdy;
    logic [DW-1:0]     rdt;
    logic              err;

    // Manager side: issues requests, consumes responses
    modport man (
        output vld, wen, adr, ben, wdt,
        input  rdy, rdt, err
    );

    // Subordinate side: accepts requests, returns responses
    modport sub (
        input  vld, wen, adr, ben, wdt,
        output rdy, rdt, err
    );
endinterface
`default_nettype wire

// File: rtl/tcb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tcb_arb
//  Description : TCB arbiter merging PN manager-side buses onto one shared
//                subordinate bus. One grant per transfer, grant frozen while
//                a transfer is stalled, delayed responses routed back to the
//                originating port through an in-order DLY-stage pipe.
//  Config      : TCB_ARB_RR_EN defined   -> round-robin arbitration
//                TCB_ARB_RR_EN undefined -> fixed priority (lowest index)
//  Revision    : 1.0  initial release
// ============================================================================
module tcb_arb #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int PN  = 2,
    parameter int DLY = 1
) (
    input  logic clk,
    input  logic rst,
    tcb_if.sub   s [PN-1:0],
    tcb_if.man   m
);

    localparam int IW = $clog2(PN);
    localparam int BW = DW / 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // flattened copies of the per-port request fields
    logic          w_vld [PN];
    logic          w_wen [PN];
    logic [AW-1:0] w_adr [PN];
    logic [BW-1:0] w_ben [PN];
    logic [DW-1:0] w_wdt [PN];

    logic [IW-1:0] w_ptr;
    logic [IW-1:0] w_sel;
    logic          w_hit;
    int            w_idx;
    logic [IW-1:0] w_gnt;
    logic          w_lck;
    logic          w_mvld;
    logic          w_hs;
    logic          w_rsp_vld;
    logic [IW-1:0] w_rsp_idx;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] own_q, own_d;

    // per-port request capture and response/ready fan-out
    for (genvar i = 0; i < PN; i++) begin : g_port
        assign w_vld[i]  = s[i].vld;
        assign w_wen[i]  = s[i].wen;
        assign w_adr[i]  = s[i].adr;
        assign w_ben[i]  = s[i].ben;
        assign w_wdt[i]  = s[i].wdt;
        assign s[i].rdy  = m.rdy & (w_gnt == IW'(i));
        assign s[i].rdt  = (w_rsp_vld && (w_rsp_idx == IW'(i))) ? m.rdt : '0;
        assign s[i].err  = w_rsp_vld && (w_rsp_idx == IW'(i)) && m.err;
    end

    // search for the first requester starting at the pointer, wrapping at PN
    always_comb begin
        w_sel = w_ptr;
        w_hit = 1'b0;
        w_idx = 0;
        for (int k = 0; k < PN; k++) begin
            w_idx = int'(w_ptr) + k;
            if (w_idx >= PN) begin
                w_idx = w_idx - PN;
            end
            if (!w_hit && w_vld[w_idx]) begin
                w_hit = 1'b1;
                w_sel = IW'(w_idx);
            end
        end
    end

    // held grant wins while locked; port 0 is forced while in reset so m
    // mirrors s[0]
    always_comb begin
        w_gnt = w_sel;
        if (!rst) begin
            w_gnt = '0;
        end else if (w_lck) begin
            w_gnt = own_q;
        end
    end

    // combinational request forwarding from the granted port
    assign w_mvld = w_vld[w_gnt];
    assign w_hs   = w_mvld & m.rdy;
    assign m.vld  = w_mvld;
    assign m.wen  = w_wen[w_gnt];
    assign m.adr  = w_adr[w_gnt];
    assign m.ben  = w_ben[w_gnt];
    assign m.wdt  = w_wdt[w_gnt];

`ifdef TCB_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    // advance the pointer past the port that just completed a handshake
    always_comb begin
        ptr_d = ptr_q;
        if (w_hs) begin
            ptr_d = (w_gnt == IW'(PN - 1)) ? '0 : w_gnt + 1'b1;
        end
    end

    // round-robin pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign w_ptr = ptr_q;
`else
    assign w_ptr = '0;
`endif

    // lock FSM state and owner registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
        end
    end

    // lock on a stalled request, release on handshake or if the owner
    // abandons its request
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        case (state_q)
            ST_IDLE: begin
                if (w_mvld && !m.rdy) begin
                    state_d = ST_HOLD;
                    own_d   = w_gnt;
                end
            end
            ST_HOLD: begin
                if (w_hs || !w_mvld) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // lock flag decoded from the FSM state
    always_comb begin
        w_lck = 1'b0;
        if (state_q == ST_HOLD) begin
            w_lck = 1'b1;
        end
    end

    // response routing: every handshake (read or write) enters the pipe so
    // both read data and write errors return to their originating port
    if (DLY == 0) begin : g_rsp_comb
        assign w_rsp_vld = w_hs & rst;
        assign w_rsp_idx = w_gnt;
    end else begin : g_rsp_pipe
        logic [DLY-1:0]         rv_q;
        logic [DLY-1:0][IW-1:0] ri_q;

        // in-order shift of {valid, port index} tags
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rv_q <= '0;
                ri_q <= '0;
            end else begin
                rv_q[0] <= w_hs;
                ri_q[0] <= w_gnt;
                for (int k = 1; k < DLY; k++) begin
                    rv_q[k] <= rv_q[k-1];
                    ri_q[k] <= ri_q[k-1];
                end
            end
        end

        assign w_rsp_vld = rv_q[DLY-1] & rst;
        assign w_rsp_idx = ri_q[DLY-1];
    end

endmodule
`default_nettype wire
